// File: rtl/adc_frame_capture.sv
// Frame capture RAM fed by the divided sample clock: skips SKIP settling ticks, then stores DEPTH samples.
// Optional over-range detection is built only when ADC_OVR_DETECT_EN is defined.
module adc_frame_capture #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SKIP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              ovr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned    SKIP_W    = (SKIP != 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [SKIP_W-1:0] SKIP_END = SKIP_W'(SKIP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sample_clk_d;
  logic               tick;
  logic [SKIP_W-1:0]  skip_cnt;
  logic [SKIP_W-1:0]  skip_inc;
  logic               start_acc;
  logic               wr_en;
  logic               settle_end;
  logic               last_wr;
  logic               busy_nxt;
  logic               done_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign tick       = sample_clk & ~sample_clk_d;
  assign skip_inc   = skip_cnt + SKIP_W'(1);
  assign start_acc  = (state == S_IDLE) & start;
  assign wr_en      = (state == S_CAPTURE) & tick;
  assign settle_end = (state == S_SETTLE) & tick & (skip_inc == SKIP_END);
  assign last_wr    = wr_en & (wr_count == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (SKIP != 0) ? S_SETTLE : S_CAPTURE;
      S_SETTLE:  if (settle_end) state_nxt = S_CAPTURE;
      S_CAPTURE: if (last_wr) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status decode of the upcoming state, registered below
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_SETTLE, S_CAPTURE: busy_nxt = 1'b1;
      S_DONE:              done_nxt = 1'b1;
      default:             ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Edge history resets high so a sample_clk already high is not a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_clk_d <= 1'b1;
      skip_cnt     <= '0;
      wr_count     <= '0;
    end else begin
      sample_clk_d <= sample_clk;
      if (start_acc) begin
        skip_cnt <= '0;
        wr_count <= '0;
      end else begin
        if ((state == S_SETTLE) && tick) skip_cnt <= skip_inc;
        if (wr_en) wr_count <= wr_count + (ADDR_W + 1)'(1);
      end
    end
  end

  // Frame RAM: contents survive reset; read returns pre-write data on a collision
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_count[ADDR_W-1:0]] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef ADC_OVR_DETECT_EN
  logic ovr_hit;
  assign ovr_hit = wr_en & ((adc_data == '0) | (adc_data == '1));

  always_ff @(posedge clk) begin
    if (rst)            ovr <= 1'b0;
    else if (start_acc) ovr <= 1'b0;
    else if (ovr_hit)   ovr <= 1'b1;
  end
`else
  assign ovr = 1'b0;
`endif

endmodule
